// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall sequencer for the 5-stage MIPS core.
// Turns load-use stall, taken-branch and data-memory handshake events into
// per-stage register enables and bubble/flush injects. It also tracks a
// memory-wait timeout and a halted state, and keeps saturating performance
// counters.
module pipeline_stall_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             w_stall,
  input  logic             w_branch_taken,
  input  logic             w_dmem_req,
  input  logic             w_dmem_ready,
  input  logic             w_halt,
  output logic             w_pc_en,
  output logic             w_fd_en,
  output logic             w_de_en,
  output logic             w_em_en,
  output logic             w_mw_en,
  output logic             w_fd_flush,
  output logic             w_de_bubble,
  output logic             w_mw_bubble,
  output logic             w_mem_err,
  output logic [1:0]       w_state,
  output logic [CNT_W-1:0] w_stall_cnt,
  output logic [CNT_W-1:0] w_wait_cnt,
  output logic [CNT_W-1:0] w_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALTED   = 2'b10
  } state_e;

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment: a counter sitting at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             shadow_q, shadow_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic stall_inc_s, wait_inc_s, flush_inc_s;
  logic run_dec_s;
  logic mem_wait_s;

  // While reset is held, every input reads as 0 so the outputs show the idle RUN decode.
  logic stall_s, branch_s, req_s, ready_s, halt_s;
  assign stall_s  = w_stall        & reset_n;
  assign branch_s = w_branch_taken & reset_n;
  assign req_s    = w_dmem_req     & reset_n;
  assign ready_s  = w_dmem_ready   & reset_n;
  assign halt_s   = w_halt         & reset_n;
  assign mem_wait_s = req_s & ~ready_s;

  // Next-state and Mealy output decode; RUN rules 2-4 are shared with the MEM_WAIT ready cycle.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    tmo_d       = tmo_q;
    mem_err_d   = mem_err_q;
    stall_inc_s = 1'b0;
    wait_inc_s  = 1'b0;
    flush_inc_s = 1'b0;
    run_dec_s   = 1'b0;
    w_pc_en     = 1'b1;
    w_fd_en     = 1'b1;
    w_de_en     = 1'b1;
    w_em_en     = 1'b1;
    w_mw_en     = 1'b1;
    w_fd_flush  = 1'b0;
    w_de_bubble = 1'b0;
    w_mw_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_wait_s) begin
          {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b00000;
          w_mw_bubble = 1'b1;
          wait_inc_s  = 1'b1;
          tmo_d       = TMO_ONE;
          state_d     = ST_MEM_WAIT;
        end else begin
          run_dec_s = 1'b1;
          if (halt_s) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!ready_s) begin
          {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b00000;
          w_mw_bubble = 1'b1;
          wait_inc_s  = 1'b1;
          tmo_d       = tmo_q + TMO_ONE;
          if (tmo_q == TMO_LAST) begin
            mem_err_d = 1'b1;
            state_d   = ST_HALTED;
          end else begin
            state_d   = ST_MEM_WAIT;
          end
        end else begin
          run_dec_s = 1'b1;
          tmo_d     = TMO_ZERO;
          state_d   = ST_RUN;
        end
      end
      ST_HALTED: begin
        {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b00000;
        w_mw_bubble = 1'b1;
        state_d     = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: freeze the pipeline and park in HALTED.
        {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b00000;
        w_mw_bubble = 1'b1;
        state_d     = ST_HALTED;
      end
    endcase

    if (run_dec_s) begin
      if (branch_s) begin
        w_fd_flush  = 1'b1;
        w_de_bubble = 1'b1;
        flush_inc_s = 1'b1;
        shadow_d    = 1'b1;
      end else if (stall_s && !shadow_q) begin
        // ID holds a real dependent instruction: freeze PC and IF/ID, bubble EX.
        w_pc_en     = 1'b0;
        w_fd_en     = 1'b0;
        w_de_bubble = 1'b1;
        stall_inc_s = 1'b1;
      end else begin
        // Pipeline advances; ID no longer holds the flushed slot.
        shadow_d = 1'b0;
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Counter next values; at most one increment flag is ever raised per cycle.
  always_comb begin
    stall_cnt_d = stall_inc_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
    wait_cnt_d  = wait_inc_s  ? sat_inc(wait_cnt_q)  : wait_cnt_q;
    flush_cnt_d = flush_inc_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // State, shadow, timeout, error flag and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      shadow_q    <= 1'b0;
      tmo_q       <= TMO_ZERO;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= CNT_ZERO;
      wait_cnt_q  <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign w_state     = state_q;
  assign w_mem_err   = mem_err_q;
  assign w_stall_cnt = stall_cnt_q;
  assign w_wait_cnt  = wait_cnt_q;
  assign w_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Self-checking bench for pipeline_stall_sequencer with narrow counters and a short timeout.
module tb_pipeline_stall_sequencer;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_n;
  logic w_stall, w_branch_taken, w_dmem_req, w_dmem_ready, w_halt;
  logic w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
  logic w_fd_flush, w_de_bubble, w_mw_bubble, w_mem_err;
  logic [1:0] w_state;
  logic [CNT_W-1:0] w_stall_cnt, w_wait_cnt, w_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: 0 RUN, 1 MEM_WAIT, 2 HALTED; plain integers for everything.
  int m_state, m_shadow, m_tmo, m_err, m_sc, m_wc, m_fc;
  int n_state, n_shadow, n_tmo, n_err_f, n_sc, n_wc, n_fc;

  pipeline_stall_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .w_stall(w_stall), .w_branch_taken(w_branch_taken),
    .w_dmem_req(w_dmem_req), .w_dmem_ready(w_dmem_ready), .w_halt(w_halt),
    .w_pc_en(w_pc_en), .w_fd_en(w_fd_en), .w_de_en(w_de_en),
    .w_em_en(w_em_en), .w_mw_en(w_mw_en),
    .w_fd_flush(w_fd_flush), .w_de_bubble(w_de_bubble), .w_mw_bubble(w_mw_bubble),
    .w_mem_err(w_mem_err), .w_state(w_state),
    .w_stall_cnt(w_stall_cnt), .w_wait_cnt(w_wait_cnt), .w_flush_cnt(w_flush_cnt)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_shadow = 0; m_tmo = 0; m_err = 0; m_sc = 0; m_wc = 0; m_fc = 0;
  endtask

  // Expected outputs from the rules; also computes the model's next state.
  task automatic check_model();
    int pc, fd, de, em, mw, fl, db, mb;
    bit waiting;
    pc = 1; fd = 1; de = 1; em = 1; mw = 1; fl = 0; db = 0; mb = 0;
    n_state = m_state; n_shadow = m_shadow; n_tmo = m_tmo; n_err_f = m_err;
    n_sc = m_sc; n_wc = m_wc; n_fc = m_fc;
    waiting = (m_state == 0 && w_dmem_req && !w_dmem_ready) || (m_state == 1 && !w_dmem_ready);
    if (m_state == 2) begin
      pc = 0; fd = 0; de = 0; em = 0; mw = 0; mb = 1;
    end else if (waiting) begin
      pc = 0; fd = 0; de = 0; em = 0; mw = 0; mb = 1;
      n_wc = sat(m_wc);
      if (m_state == 0) begin
        n_tmo = 1; n_state = 1;
      end else begin
        n_tmo = m_tmo + 1;
        if (n_tmo == MEM_TIMEOUT) begin n_err_f = 1; n_state = 2; end
      end
    end else begin
      if (w_branch_taken) begin
        fl = 1; db = 1; n_fc = sat(m_fc); n_shadow = 1;
      end else if (w_stall && m_shadow == 0) begin
        pc = 0; fd = 0; db = 1; n_sc = sat(m_sc);
      end else begin
        n_shadow = 0;
      end
      n_state = (m_state == 0 && w_halt) ? 2 : 0;
      if (m_state == 1) n_tmo = 0;
    end
    chk("pc_en", w_pc_en, pc);       chk("fd_en", w_fd_en, fd);
    chk("de_en", w_de_en, de);       chk("em_en", w_em_en, em);
    chk("mw_en", w_mw_en, mw);       chk("fd_flush", w_fd_flush, fl);
    chk("de_bubble", w_de_bubble, db); chk("mw_bubble", w_mw_bubble, mb);
    chk("state", w_state, m_state);  chk("mem_err", w_mem_err, m_err);
    chk("stall_cnt", w_stall_cnt, m_sc); chk("wait_cnt", w_wait_cnt, m_wc);
    chk("flush_cnt", w_flush_cnt, m_fc);
  endtask

  task automatic drive(input bit s, input bit b, input bit rq, input bit rd, input bit h);
    w_stall = s; w_branch_taken = b; w_dmem_req = rq; w_dmem_ready = rd; w_halt = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_state = n_state; m_shadow = n_shadow; m_tmo = n_tmo; m_err = n_err_f;
    m_sc = n_sc; m_wc = n_wc; m_fc = n_fc;
  endtask

  task automatic step(input bit s, input bit b, input bit rq, input bit rd, input bit h);
    drive(s, b, rq, rd, h);
    check_model();
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en}, 5'b11111);
    chk({tag, "_flush"}, {w_fd_flush, w_de_bubble, w_mw_bubble}, 0);
    chk({tag, "_state"}, w_state, 0);
    chk({tag, "_err"}, w_mem_err, 0);
    chk({tag, "_cnts"}, {w_stall_cnt, w_wait_cnt, w_flush_cnt}, 0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset();

    // Load-use stall in RUN.
    step(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0); check_model();
    chk("ld_pc_en", w_pc_en, 0); chk("ld_de_bubble", w_de_bubble, 1); chk("ld_em_en", w_em_en, 1);
    tick();
    chk("ld_stall_cnt", w_stall_cnt, 1);

    // Branch with simultaneous stall, then stall shadowed, then applied.
    drive(1, 1, 0, 0, 0); check_model();
    chk("br_fd_flush", w_fd_flush, 1); chk("br_pc_en", w_pc_en, 1);
    tick();
    chk("br_stall_cnt", w_stall_cnt, 1); chk("br_flush_cnt", w_flush_cnt, 1);
    drive(1, 0, 0, 0, 0); check_model(); chk("shadow_pc_en", w_pc_en, 1); tick();
    drive(1, 0, 0, 0, 0); check_model(); chk("after_pc_en", w_pc_en, 0); tick();
    chk("after_stall_cnt", w_stall_cnt, 2);
    step(0, 0, 0, 0, 0);

    // Memory wait of three cycles, then ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0); check_model(); chk("mw_bubble_lit", w_mw_bubble, 1); tick();
    end
    chk("mw_state", w_state, 1);
    drive(0, 0, 1, 1, 0); check_model(); chk("rdy_pc_en", w_pc_en, 1); tick();
    chk("rdy_state", w_state, 0); chk("rdy_wait_cnt", w_wait_cnt, 3);

    // Branch on the ready cycle: only flush_cnt moves; shadow survives a later wait.
    step(0, 0, 1, 0, 0);
    drive(1, 1, 1, 1, 0); check_model(); chk("rdybr_flush", w_fd_flush, 1); tick();
    chk("rdybr_flush_cnt", w_flush_cnt, 1); chk("rdybr_stall_cnt", w_stall_cnt, 0);
    step(0, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0); check_model(); chk("shadow_wait_pc", w_pc_en, 1); tick();

    // Halt from RUN, then nothing moves.
    step(0, 0, 0, 0, 1);
    chk("halt_state", w_state, 2);
    step(1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("halt_flush_cnt", w_flush_cnt, 1);

    // Timeout after four wait cycles; HALTED is sticky until reset.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("tmo_state", w_state, 2); chk("tmo_err", w_mem_err, 1);
    step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("tmo_hold_state", w_state, 2); chk("tmo_hold_err", w_mem_err, 1);
    chk("tmo_wait_cnt", w_wait_cnt, 3);
    do_reset();

    // Counter saturation: five flushes on a 2-bit counter.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("sat_flush_cnt", w_flush_cnt, 3);

    // Async reset between edges in MEM_WAIT, with the wait inputs still applied.
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre_async_state", w_state, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    reset_n = 1'b1;
    #1;
    step(0, 0, 0, 0, 0);

    // Mixed traffic against the model, halt kept low.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
